blinky_checker: RTL and testbench

BLINKY_CHECKER -- requirements
Module: blinky_checker

---
 rtl/blinky_pkg.sv | 14 +
 rtl/blinky_edge_det.sv | 43 ++++
 rtl/blinky_checker.sv | 154 +++++++++++++++
 tb/tb_blinky_checker.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/blinky_pkg.sv
// blinky_pkg: shared types and constants for the blinky_checker block.
//   CNT_W   - width of the half-period cycle counter and half_period output
//   state_e - checker FSM states
package blinky_pkg;

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

endpackage

// File: rtl/blinky_edge_det.sv
// blinky_edge_det: 2-flop synchronizer plus any-edge detector.
// Ports:
//   clk        - clock
//   rst_n      - asynchronous active-low reset
//   d          - asynchronous input
//   edge_pulse - one-cycle pulse, registered, 3 clk cycles after a change on d
module blinky_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic edge_q,  edge_d;

  // Next-state: shift the synchronizer and compare the last two synchronized samples.
  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_d  = sync2_q ^ prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_pulse = edge_q;

endmodule

// File: rtl/blinky_checker.sv
// blinky_checker: measures the half-period of a blinking input and reports
// whether it toggles every clk_freq_hz cycles within +/- tol_cycles.
// Ports:
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   d           - blink signal under test (asynchronous)
//   valid       - one-cycle pulse: half_period holds a new measurement
//   half_period - last measured cycles between edges of d
//   locked      - high while d toggles inside the accepted window
//   err         - one-cycle pulse on an out-of-window edge or a timeout
//   err_cnt     - saturating error count; only counts when
//                 BLINKY_CHECKER_ERR_CNT_EN is defined, otherwise tied to 0
module blinky_checker
  import blinky_pkg::*;
#(
  parameter int unsigned clk_freq_hz = 125_000_000,
  parameter int unsigned tol_cycles  = 1000,
  parameter int unsigned lock_count  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d,
  output logic             valid,
  output logic [CNT_W-1:0] half_period,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned      MATCH_W = 4;
  localparam logic [CNT_W-1:0] EXP     = CNT_W'(clk_freq_hz);
  localparam logic [CNT_W-1:0] TOL     = CNT_W'(tol_cycles);
  localparam logic [CNT_W-1:0] WIN_LO  = EXP - TOL;
  localparam logic [CNT_W-1:0] WIN_HI  = EXP + TOL;
  localparam logic [CNT_W-1:0] TIMEOUT = WIN_HI + CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [MATCH_W-1:0] LOCK_N = MATCH_W'(lock_count);

  logic edge_pulse;

  blinky_edge_det u_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (d),
    .edge_pulse (edge_pulse)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hp_q, hp_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MATCH_W-1:0] match_inc;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               in_win;

  // Next-state: measurement, window check, lock tracking and timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hp_d      = hp_q;
    match_d   = match_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    locked_d  = (state_q == ST_LOCKED);  // lags state by one cycle, so it drops after err
    in_win    = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    match_inc = match_q + MATCH_W'(1);

    if (edge_pulse) begin
      // Edge wins over a coincident timeout: a late edge is judged as out-of-window.
      cnt_d = CNT_W'(1);
      hp_d  = cnt_q;
      unique case (state_q)
        ST_SEARCH: begin
          // The first edge only marks the start; the period before it is unknown.
          state_d = ST_MEASURE;
          match_d = '0;
        end
        ST_MEASURE: begin
          valid_d = 1'b1;
          if (in_win) begin
            match_d = match_inc;
            if (match_inc >= LOCK_N) state_d = ST_LOCKED;
          end else begin
            err_d   = 1'b1;
            match_d = '0;
          end
        end
        ST_LOCKED: begin
          valid_d = 1'b1;
          if (!in_win) begin
            err_d   = 1'b1;
            match_d = '0;
            state_d = ST_MEASURE;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if ((state_q != ST_SEARCH) && (cnt_q >= TIMEOUT)) begin
        err_d   = 1'b1;
        match_d = '0;
        state_d = ST_SEARCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      cnt_q    <= '0;
      hp_q     <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign valid       = valid_q;
  assign half_period = hp_q;
  assign locked      = locked_q;
  assign err         = err_q;

`ifdef BLINKY_CHECKER_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count, updated together with the err pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_blinky_checker.sv
// tb_blinky_checker: directed self-checking bench for blinky_checker
// (clk_freq_hz=100, tol_cycles=2, lock_count=3).
module tb_blinky_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d = 1'b0;
  logic        valid;
  logic [31:0] half_period;
  logic        locked;
  logic        err;
  logic [7:0]  err_cnt;

  int          checks = 0;
  int          failures = 0;
  int          n_valid;
  int          n_err;
  logic [31:0] last_hp;

`ifdef BLINKY_CHECKER_ERR_CNT_EN
  localparam int        N_TO    = 300;
  localparam logic [7:0] EXP_MID = 8'd3;
  localparam logic [7:0] EXP_END = 8'd255;
`else
  localparam int        N_TO    = 3;
  localparam logic [7:0] EXP_MID = 8'd0;
  localparam logic [7:0] EXP_END = 8'd0;
`endif

  always #5 clk = ~clk;

  blinky_checker #(
    .clk_freq_hz (100),
    .tol_cycles  (2),
    .lock_count  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .valid       (valid),
    .half_period (half_period),
    .locked      (locked),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  // Toggle d, then observe n cycles (sampled on the falling edge).
  task automatic toggle_wait(input int n);
    d       = ~d;
    n_valid = 0;
    n_err   = 0;
    last_hp = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        n_valid++;
        last_hp = half_period;
      end
      if (err === 1'b1) n_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d     = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (half_period !== 32'd0) begin failures++; $display("FAIL reset_half_period got=%0d exp=0", half_period); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lock();
    for (int k = 1; k <= 6; k++) begin
      toggle_wait(100);
      checks++;
      if (n_valid != ((k >= 2) ? 1 : 0)) begin
        failures++; $display("FAIL lock_valid_edge%0d got=%0d exp=%0d", k, n_valid, (k >= 2) ? 1 : 0);
      end
      if (k >= 2) begin
        checks++;
        if (last_hp !== 32'd100) begin failures++; $display("FAIL lock_hp_edge%0d got=%0d exp=100", k, last_hp); end
      end
      checks++;
      if (n_err != 0) begin failures++; $display("FAIL lock_err_edge%0d got=%0d exp=0", k, n_err); end
      checks++;
      if (locked !== ((k >= 4) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL lock_locked_edge%0d got=%0b exp=%0b", k, locked, (k >= 4) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic test_timeout();
    int err_at  = 0;
    int fall_at = 0;
    int errs    = 0;
    int vals    = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        errs++;
        if (err_at == 0) err_at = i;
      end
      if (valid === 1'b1) vals++;
      if ((locked !== 1'b1) && (fall_at == 0)) fall_at = i;
    end
    checks++; if (errs != 1) begin failures++; $display("FAIL timeout_err_count got=%0d exp=1", errs); end
    checks++; if (err_at != 7) begin failures++; $display("FAIL timeout_err_cycle got=%0d exp=7", err_at); end
    checks++; if (fall_at != 8) begin failures++; $display("FAIL timeout_locked_fall got=%0d exp=8", fall_at); end
    checks++; if (vals != 0) begin failures++; $display("FAIL timeout_valid got=%0d exp=0", vals); end
  endtask

  task automatic test_window();
    int          dur   [8] = '{98, 102, 97, 103, 100, 100, 100, 100};
    int          exp_v [8] = '{0, 1, 1, 1, 1, 1, 1, 1};
    int          exp_e [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    logic [31:0] exp_hp[8] = '{0, 98, 102, 97, 103, 100, 100, 100};
    logic        exp_l [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    for (int k = 0; k < 8; k++) begin
      toggle_wait(dur[k]);
      checks++;
      if (n_valid != exp_v[k]) begin failures++; $display("FAIL window_valid_%0d got=%0d exp=%0d", k, n_valid, exp_v[k]); end
      checks++;
      if (n_err != exp_e[k]) begin failures++; $display("FAIL window_err_%0d got=%0d exp=%0d", k, n_err, exp_e[k]); end
      if (exp_v[k] != 0) begin
        checks++;
        if (last_hp !== exp_hp[k]) begin failures++; $display("FAIL window_hp_%0d got=%0d exp=%0d", k, last_hp, exp_hp[k]); end
      end
      checks++;
      if (locked !== exp_l[k]) begin failures++; $display("FAIL window_locked_%0d got=%0b exp=%0b", k, locked, exp_l[k]); end
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rstmid_pre_locked got=%0b exp=1", locked); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", valid); end
    checks++; if (half_period !== 32'd0) begin failures++; $display("FAIL rstmid_hp got=%0d exp=0", half_period); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rstmid_locked got=%0b exp=0", locked); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%0b exp=0", err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_err_cnt got=%0d exp=0", err_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    toggle_wait(100);
    checks++; if (n_valid != 0) begin failures++; $display("FAIL rstmid_first_valid got=%0d exp=0", n_valid); end
    checks++; if (n_err != 0) begin failures++; $display("FAIL rstmid_first_err got=%0d exp=0", n_err); end
    toggle_wait(100);
    checks++; if (n_valid != 1) begin failures++; $display("FAIL rstmid_second_valid got=%0d exp=1", n_valid); end
    checks++; if (last_hp !== 32'd100) begin failures++; $display("FAIL rstmid_second_hp got=%0d exp=100", last_hp); end
  endtask

  task automatic test_err_cnt();
    int total = 0;
    for (int i = 1; i <= N_TO; i++) begin
      toggle_wait(110);
      total += n_err;
      if (i == 3) begin
        checks++;
        if (err_cnt !== EXP_MID) begin failures++; $display("FAIL errcnt_mid got=%0d exp=%0d", err_cnt, EXP_MID); end
      end
    end
    checks++; if (total != N_TO) begin failures++; $display("FAIL errcnt_pulses got=%0d exp=%0d", total, N_TO); end
    checks++; if (err_cnt !== EXP_END) begin failures++; $display("FAIL errcnt_final got=%0d exp=%0d", err_cnt, EXP_END); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_timeout();
    test_window();
    test_reset_mid();
    test_err_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
